branch_sequencer: RTL
=====================

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, max T1 cycles waiting on in_mem_ready before error (1..15).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 clr  input  1  reset, synchronous, active-high.
REQ-004 in_start  input  1  request to execute one conditional-branch instruction (brzr/brnz/brpl/brmi).
REQ-005 in_mem_ready  input  1  memory read data valid on Mdatain this cycle.
REQ-006 in_con  input  1  CON flip-flop output (branch condition result).
REQ-007 out_pc_out, out_mar_in, out_inc_pc, out_z_in, out_zlo_out, out_pc_in  output  1 each  datapath strobes.
REQ-008 out_read, out_mdr_in, out_mdr_out, out_ir_in  output  1 each  memory/IR strobes.
REQ-009 out_gra, out_r_out, out_con_in, out_y_in, out_c_out, out_alu_add  output  1 each  operand/CON/ALU strobes.
REQ-010 out_busy  output  1  high in any state except IDLE, DONE and ERR.
REQ-011 out_done  output  1  one-cycle completion pulse.
REQ-012 out_taken  output  1  registered branch outcome of last completed instruction.
REQ-013 out_error  output  1  memory timeout flag, sticky.
REQ-014 out_state  output  4  current state code, for debug.

Function
REQ-015 States/codes SHALL be IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, DONE=8, ERR=9; all strobes Moore-decoded from state only.
REQ-016 IDLE: no strobes; in_start=1 -> T0 next cycle, else stay.
REQ-017 T0: pc_out, mar_in, inc_pc, z_in; -> T1 unconditionally.
REQ-018 T1: zlo_out, pc_in, read, mdr_in asserted every T1 cycle; in_mem_ready=1 -> T2; else stay and increment wait counter.
REQ-019 Wait counter 4 bits, cleared on entry to T1; ready=0 with counter==MEM_TIMEOUT-1 -> ERR (T1 occupies at most MEM_TIMEOUT cycles); ready=1 on that same cycle takes priority -> T2.
REQ-020 T2: mdr_out, ir_in; -> T3.
REQ-021 T3: gra, r_out, con_in; -> T4 (CON FF latches at end of T3).
REQ-022 T4: pc_out, y_in; -> T5.
REQ-023 T5: c_out, alu_add, z_in; -> T6.
REQ-024 T6: zlo_out always; pc_in only if in_con=1; out_taken loaded with in_con at end of T6; -> DONE.
REQ-025 DONE: out_done=1 for exactly one cycle; in_start=1 -> T0 (back-to-back), else -> IDLE.
REQ-026 in_start SHALL be ignored in T0..T6 and ERR; no queuing.
REQ-027 ERR: no strobes, out_error=1, stays until clr; in_start ignored.
REQ-028 Minimum latency start->done: 8 cycles with in_mem_ready=1 in first T1 cycle (T0..T6 + DONE); each extra T1 wait cycle adds one.
REQ-029 out_taken SHALL hold its value from DONE until the next T6 or clr.

Reset
REQ-030 clr=1 at a rising edge SHALL, regardless of state, set state=IDLE, wait counter=0, out_taken=0, out_error=0; all strobes, out_busy and out_done 0 from the following cycle.
REQ-031 clr SHALL take priority over in_start and every state transition; clr mid-instruction aborts with no further strobes.

Verification
REQ-032 clr, then in_start=1 one cycle, ready=1 in first T1, in_con=1 -> out_state 1,2,3,4,5,6,7,8,0; pc_in in T1 and T6; out_done at cycle 8; out_taken=1.
REQ-033 Same with in_con=0 -> pc_in absent in T6, zlo_out still asserted, out_taken=0 after DONE.
REQ-034 ready held 0 for 3 T1 cycles then 1 -> T1 lasts 4 cycles, read/mdr_in high all 4, done at cycle 11, out_error=0.
REQ-035 ready never asserted, MEM_TIMEOUT=15 -> ERR after 15 T1 cycles, out_error=1, out_busy=0; in_start ignored; clr -> IDLE, out_error=0.
REQ-036 in_start held 1 continuously -> second instruction T0 immediately after DONE (no IDLE cycle); pulses during T0..T6 ignored.
REQ-037 clr asserted during T4 -> next cycle state=0, all strobes 0, out_taken=0, no out_done.

Source files
------------

// File: rtl/branch_sequencer.sv
// Control sequencer for one conditional-branch instruction (brzr/brnz/brpl/brmi).
// Walks T0..T6 issuing Moore-decoded datapath strobes, waits in T1 for memory
// with a bounded timeout, and reports completion, branch outcome and error.
//
// Ports:
//   clk, clr          clock and synchronous active-high reset
//   in_start          start one instruction (honoured only in IDLE and DONE)
//   in_mem_ready      memory read data valid this cycle
//   in_con            CON flip-flop output (branch condition)
//   out_* strobes     datapath, memory/IR and operand/ALU control strobes
//   out_busy          high while executing T0..T6
//   out_done          one-cycle completion pulse
//   out_taken         outcome of the last completed instruction
//   out_error         memory timeout flag, held until clr
//   out_state         current state code for debug
module branch_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       in_start,
    input  logic       in_mem_ready,
    input  logic       in_con,
    output logic       out_pc_out,
    output logic       out_mar_in,
    output logic       out_inc_pc,
    output logic       out_z_in,
    output logic       out_zlo_out,
    output logic       out_pc_in,
    output logic       out_read,
    output logic       out_mdr_in,
    output logic       out_mdr_out,
    output logic       out_ir_in,
    output logic       out_gra,
    output logic       out_r_out,
    output logic       out_con_in,
    output logic       out_y_in,
    output logic       out_c_out,
    output logic       out_alu_add,
    output logic       out_busy,
    output logic       out_done,
    output logic       out_taken,
    output logic       out_error,
    output logic [3:0] out_state
);

    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StT0   = 4'd1,
        StT1   = 4'd2,
        StT2   = 4'd3,
        StT3   = 4'd4,
        StT4   = 4'd5,
        StT5   = 4'd6,
        StT6   = 4'd7,
        StDone = 4'd8,
        StErr  = 4'd9
    } state_e;

    // Last wait-counter value before T1 gives up; T1 lasts at most MEM_TIMEOUT cycles.
    localparam logic [3:0] WaitLast = 4'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       taken_q, taken_d;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            wait_q  <= 4'd0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            taken_q <= taken_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        taken_d = taken_q;
        unique case (state_q)
            StIdle: if (in_start) state_d = StT0;
            StT0: begin
                state_d = StT1;
                wait_d  = 4'd0;
            end
            StT1: begin
                // Ready on the final allowed cycle still wins over the timeout.
                if (in_mem_ready) begin
                    state_d = StT2;
                end else if (wait_q == WaitLast) begin
                    state_d = StErr;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            StT2: state_d = StT3;
            StT3: state_d = StT4;
            StT4: state_d = StT5;
            StT5: state_d = StT6;
            StT6: begin
                state_d = StDone;
                taken_d = in_con;
            end
            StDone: state_d = in_start ? StT0 : StIdle;
            StErr:  state_d = StErr;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_pc_out  = 1'b0;
        out_mar_in  = 1'b0;
        out_inc_pc  = 1'b0;
        out_z_in    = 1'b0;
        out_zlo_out = 1'b0;
        out_pc_in   = 1'b0;
        out_read    = 1'b0;
        out_mdr_in  = 1'b0;
        out_mdr_out = 1'b0;
        out_ir_in   = 1'b0;
        out_gra     = 1'b0;
        out_r_out   = 1'b0;
        out_con_in  = 1'b0;
        out_y_in    = 1'b0;
        out_c_out   = 1'b0;
        out_alu_add = 1'b0;
        unique case (state_q)
            StT0: begin
                out_pc_out = 1'b1;
                out_mar_in = 1'b1;
                out_inc_pc = 1'b1;
                out_z_in   = 1'b1;
            end
            StT1: begin
                out_zlo_out = 1'b1;
                out_pc_in   = 1'b1;
                out_read    = 1'b1;
                out_mdr_in  = 1'b1;
            end
            StT2: begin
                out_mdr_out = 1'b1;
                out_ir_in   = 1'b1;
            end
            StT3: begin
                out_gra    = 1'b1;
                out_r_out  = 1'b1;
                out_con_in = 1'b1;
            end
            StT4: begin
                out_pc_out = 1'b1;
                out_y_in   = 1'b1;
            end
            StT5: begin
                out_c_out   = 1'b1;
                out_alu_add = 1'b1;
                out_z_in    = 1'b1;
            end
            StT6: begin
                // Branch target is written back only when the condition holds.
                out_zlo_out = 1'b1;
                out_pc_in   = in_con;
            end
            default: ;
        endcase
    end

    assign out_busy  = (state_q >= StT0) && (state_q <= StT6);
    assign out_done  = (state_q == StDone);
    assign out_error = (state_q == StErr);
    assign out_taken = taken_q;
    assign out_state = state_q;

endmodule
